// File: rtl/demultiplexer1to2_buffered.sv
// 1-to-2 stream demultiplexer with a one-entry registered holding stage per output.
// Optional per-side accept counters (count0/count1) are enabled by DEMUX_TRANSFER_COUNT_EN.

module demux_hold_stage #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [NBITS-1:0] data,
  output logic             can_load
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        data_q <= load_data;
      end
    end
  end

  // A drain and a load in the same cycle keep the stage FULL with the new word.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (load) state_next = FULL;
      FULL:  if (ready && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign valid    = (state == FULL);
  assign data     = data_q;
  assign can_load = ~valid | ready;

endmodule

module demultiplexer1to2_buffered #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_selector,
  input  logic [NBITS-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [NBITS-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [NBITS-1:0] out1_data
`ifdef DEMUX_TRANSFER_COUNT_EN
  ,
  output logic [15:0]      count0,
  output logic [15:0]      count1
`endif
);

  logic can_load0;
  logic can_load1;
  logic accept;
  logic load0;
  logic load1;

  // Readiness depends only on the selected side's stage.
  assign in_ready = in_selector ? can_load1 : can_load0;
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~in_selector;
  assign load1    = accept & in_selector;

  demux_hold_stage #(.NBITS(NBITS)) u_stage0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .load_data (in_data),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .can_load  (can_load0)
  );

  demux_hold_stage #(.NBITS(NBITS)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .load_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .can_load  (can_load1)
  );

`ifdef DEMUX_TRANSFER_COUNT_EN
  logic [15:0] count0_q;
  logic [15:0] count1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (load0) count0_q <= count0_q + 16'd1;
      if (load1) count1_q <= count1_q + 16'd1;
    end
  end

  assign count0 = count0_q;
  assign count1 = count1_q;
`endif

endmodule

// File: tb/tb_demultiplexer1to2_buffered.sv
// Self-checking bench for demultiplexer1to2_buffered: directed scenarios plus random traffic
// checked against a behavioural model of two single-entry buffers.

module tb_demultiplexer1to2_buffered;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_selector;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef DEMUX_TRANSFER_COUNT_EN
  logic [15:0] count0;
  logic [15:0] count1;
`endif

  int vectors;
  int miscompares;

  // Model: each side is a buffer of capacity one holding its last loaded word.
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_count [2];

  demultiplexer1to2_buffered #(.NBITS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_selector (in_selector),
    .in_data     (in_data),
    .out0_valid  (out0_valid),
    .out0_ready  (out0_ready),
    .out0_data   (out0_data),
    .out1_valid  (out1_valid),
    .out1_ready  (out1_ready),
    .out1_data   (out1_data)
`ifdef DEMUX_TRANSFER_COUNT_EN
    ,
    .count0      (count0),
    .count1      (count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model at the edge, check outputs.
  task automatic cycle(input logic rst, input logic iv, input logic sel,
                       input logic [31:0] d, input logic r0, input logic r1);
    bit exp_ready;
    bit rdy [2];
    reset       = rst;
    in_valid    = iv;
    in_selector = sel;
    in_data     = d;
    out0_ready  = r0;
    out1_ready  = r1;
    rdy[0] = r0;
    rdy[1] = r1;
    #1;
    exp_ready = !m_valid[sel] || rdy[sel];
    if (!rst) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
        m_count[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (m_valid[k] && rdy[k]) m_valid[k] = 1'b0;
      if (iv && exp_ready) begin
        m_valid[sel] = 1'b1;
        m_data[sel]  = d;
        m_count[sel] = (m_count[sel] + 1) % 65536;
      end
    end
    #1;
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, m_valid[0]});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, m_valid[1]});
    chk("out0_data", out0_data, m_data[0]);
    chk("out1_data", out1_data, m_data[1]);
`ifdef DEMUX_TRANSFER_COUNT_EN
    chk("count0", {16'd0, count0}, m_count[0]);
    chk("count1", {16'd0, count1}, m_count[1]);
`endif
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_count[k] = 0;
    end
    reset = 1'b1; in_valid = 1'b0; in_selector = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 32'h0, 0, 0);
    cycle(1, 0, 0, 32'h0, 0, 0);
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);

    // Reset mid-transfer drops the held word
    cycle(0, 1, 1, 32'hDEADBEEF, 0, 0);
    chk("mid_loaded", out1_data, 32'hDEADBEEF);
    cycle(1, 0, 0, 32'h0, 0, 0);
    chk("mid_rst_valid", {31'd0, out1_valid}, 32'd0);
    chk("mid_rst_data", out1_data, 32'd0);
    cycle(0, 0, 0, 32'h0, 1, 1);
    chk("mid_never_delivered", {31'd0, out1_valid}, 32'd0);

    // Basic routing
    cycle(0, 1, 0, 32'h00000011, 1, 1);
    chk("route0_data", out0_data, 32'h11);
    chk("route0_other", {31'd0, out1_valid}, 32'd0);
    cycle(0, 1, 1, 32'h00000022, 1, 1);
    chk("route1_data", out1_data, 32'h22);
    chk("route1_other", {31'd0, out0_valid}, 32'd0);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Backpressure isolation
    cycle(0, 1, 0, 32'hA5A5A5A5, 0, 1);
    cycle(0, 1, 0, 32'h12345678, 0, 1);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold", out0_data, 32'hA5A5A5A5);
    cycle(0, 1, 1, 32'h5A5A5A5A, 0, 1);
    chk("bp_other_side", out1_data, 32'h5A5A5A5A);
    chk("bp_still_hold", out0_data, 32'hA5A5A5A5);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Full throughput on side 1
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 1, i, 1, 1);
      chk("thru_data", out1_data, i);
      chk("thru_valid", {31'd0, out1_valid}, 32'd1);
    end
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Simultaneous drain of both sides plus accept to side 0
    cycle(0, 1, 0, 32'h1, 0, 0);
    cycle(0, 1, 1, 32'h3, 0, 0);
    cycle(0, 1, 0, 32'h2, 1, 1);
    chk("sim_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("sim_out0_data", out0_data, 32'h2);
    chk("sim_out1_valid", {31'd0, out1_valid}, 32'd0);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++)
      cycle((n % 97) == 96, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

`ifdef DEMUX_TRANSFER_COUNT_EN
    // Counters with wrap on side 1
    cycle(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, i, 1, 1);
    for (int i = 0; i < 65537; i++) cycle(0, 1, 1, i, 1, 1);
    chk("cnt0_final", {16'd0, count0}, 32'd3);
    chk("cnt1_wrapped", {16'd0, count1}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
